// File: rtl/dino_pkg.sv
// rtl/dino_pkg.sv - shared dino game types, FSM encodings and geometry defaults
package dino_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    OVER = 2'd2
  } game_state_e;

  typedef enum logic {
    OBS_CACTUS = 1'b0,
    OBS_BIRD   = 1'b1
  } obs_kind_e;

  localparam logic [7:0]  SCREEN_R_D     = 8'd159;
  localparam logic [7:0]  PLAYER_X_D     = 8'd16;
  localparam logic [7:0]  PLAYER_W_D     = 8'd8;
  localparam logic [7:0]  PLAYER_H_D     = 8'd16;
  localparam logic [7:0]  PLAYER_DH_D    = 8'd8;
  localparam logic [7:0]  CACTUS_W_D     = 8'd6;
  localparam logic [7:0]  CACTUS_H_D     = 8'd12;
  localparam logic [7:0]  BIRD_W_D       = 8'd10;
  localparam logic [7:0]  BIRD_Y_D       = 8'd10;
  localparam logic [7:0]  BIRD_H_D       = 8'd6;
  localparam logic [5:0]  MIN_GAP_D      = 6'd24;
  localparam logic [2:0]  SPEED_INIT_D   = 3'd1;
  localparam logic [2:0]  SPEED_MAX_D    = 3'd6;
  localparam logic [9:0]  SPEED_PERIOD_D = 10'd600;
  localparam logic [15:0] LFSR_SEED_D    = 16'hACE1;

  // Right-shifting Galois LFSR, taps 16,14,13,11; a nonzero state never maps to zero.
  function automatic logic [15:0] lfsr_next(input logic [15:0] cur);
    return {1'b0, cur[15:1]} ^ (cur[0] ? 16'hB400 : 16'h0000);
  endfunction

endpackage

// File: rtl/obstacle_slot.sv
// rtl/obstacle_slot.sv - one obstacle slot: scroll, retire, load and player-overlap term
module obstacle_slot
  import dino_pkg::*;
#(
  parameter logic [7:0] SCREEN_R  = SCREEN_R_D,
  parameter logic [7:0] PLAYER_X  = PLAYER_X_D,
  parameter logic [7:0] PLAYER_W  = PLAYER_W_D,
  parameter logic [7:0] PLAYER_H  = PLAYER_H_D,
  parameter logic [7:0] PLAYER_DH = PLAYER_DH_D,
  parameter logic [7:0] CACTUS_W  = CACTUS_W_D,
  parameter logic [7:0] CACTUS_H  = CACTUS_H_D,
  parameter logic [7:0] BIRD_W    = BIRD_W_D,
  parameter logic [7:0] BIRD_Y    = BIRD_Y_D,
  parameter logic [7:0] BIRD_H    = BIRD_H_D
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clear_i,
  input  logic       scroll_i,
  input  logic       load_i,
  input  logic       load_type_i,
  input  logic [2:0] speed_i,
  input  logic [7:0] player_pos_i,
  input  logic       ducking_i,
  output logic       valid_o,
  output logic       type_o,
  output logic [7:0] x_o,
  output logic       free_o,
  output logic       hit_o
);

  logic       valid_q, valid_d;
  logic       type_q, type_d;
  logic [7:0] x_q, x_d;
  logic       retire;
  logic [8:0] obs_w, obs_y_lo, obs_y_hi, ply_y_hi;
  logic       x_ov, y_ov;

  // A slot that would scroll past the left edge is dropped rather than wrapped.
  assign retire = scroll_i && valid_q && (x_q < {5'd0, speed_i});
  assign free_o = !valid_q || retire;

  // Slot next state: clear beats load, load beats retire/scroll.
  always_comb begin
    valid_d = valid_q;
    type_d  = type_q;
    x_d     = x_q;
    if (clear_i) begin
      valid_d = 1'b0;
      type_d  = OBS_CACTUS;
      x_d     = 8'd0;
    end else if (load_i) begin
      valid_d = 1'b1;
      type_d  = load_type_i;
      x_d     = SCREEN_R;
    end else if (retire) begin
      valid_d = 1'b0;
    end else if (scroll_i && valid_q) begin
      x_d = x_q - {5'd0, speed_i};
    end
  end

  // Slot registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      type_q  <= OBS_CACTUS;
      x_q     <= 8'd0;
    end else begin
      valid_q <= valid_d;
      type_q  <= type_d;
      x_q     <= x_d;
    end
  end

  // Half-open box overlap in 9 bits so right/top edges cannot overflow.
  assign obs_w    = type_q ? {1'b0, BIRD_W} : {1'b0, CACTUS_W};
  assign obs_y_lo = type_q ? {1'b0, BIRD_Y} : 9'd0;
  assign obs_y_hi = type_q ? ({1'b0, BIRD_Y} + {1'b0, BIRD_H}) : {1'b0, CACTUS_H};
  assign ply_y_hi = {1'b0, player_pos_i} + (ducking_i ? {1'b0, PLAYER_DH} : {1'b0, PLAYER_H});
  assign x_ov     = ({1'b0, PLAYER_X} < ({1'b0, x_q} + obs_w)) &&
                    ({1'b0, x_q} < ({1'b0, PLAYER_X} + {1'b0, PLAYER_W}));
  assign y_ov     = ({1'b0, player_pos_i} < obs_y_hi) && (obs_y_lo < ply_y_hi);
  assign hit_o    = valid_q && x_ov && y_ov;

  assign valid_o = valid_q;
  assign type_o  = type_q;
  assign x_o     = x_q;

endmodule

// File: rtl/obstacle_controller.sv
// rtl/obstacle_controller.sv - obstacle spawn/scroll/retire, speed ramp and crash detection
module obstacle_controller
  import dino_pkg::*;
#(
  parameter int          NUM_OBS      = 2,
  parameter logic [7:0]  SCREEN_R     = SCREEN_R_D,
  parameter logic [7:0]  PLAYER_X     = PLAYER_X_D,
  parameter logic [7:0]  PLAYER_W     = PLAYER_W_D,
  parameter logic [7:0]  PLAYER_H     = PLAYER_H_D,
  parameter logic [7:0]  PLAYER_DH    = PLAYER_DH_D,
  parameter logic [7:0]  CACTUS_W     = CACTUS_W_D,
  parameter logic [7:0]  CACTUS_H     = CACTUS_H_D,
  parameter logic [7:0]  BIRD_W       = BIRD_W_D,
  parameter logic [7:0]  BIRD_Y       = BIRD_Y_D,
  parameter logic [7:0]  BIRD_H       = BIRD_H_D,
  parameter logic [5:0]  MIN_GAP      = MIN_GAP_D,
  parameter logic [2:0]  SPEED_INIT   = SPEED_INIT_D,
  parameter logic [2:0]  SPEED_MAX    = SPEED_MAX_D,
  parameter logic [9:0]  SPEED_PERIOD = SPEED_PERIOD_D,
  parameter logic [15:0] LFSR_SEED    = LFSR_SEED_D
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [1:0]             game_tick,
  input  logic                   game_start_pulse,
  input  logic                   game_over_pulse,
  input  logic [7:0]             player_position,
  input  logic                   ducking,
  output logic                   crash,
  output logic [NUM_OBS-1:0]     obs_valid,
  output logic [NUM_OBS-1:0]     obs_type,
  output logic [8*NUM_OBS-1:0]   obs_x,
  output logic [2:0]             speed
);

  game_state_e        state_q, state_d;
  logic               run;
  logic [15:0]        lfsr_q;
  logic [5:0]         gap_q, gap_d, gap_dec;
  logic [9:0]         fcnt_q, fcnt_d;
  logic [2:0]         speed_q, speed_d;
  logic               crash_q, crash_d;
  logic               scroll, spawn_en;
  logic [NUM_OBS-1:0] free, load, hit;

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // FSM next state: a start pulse always (re)enters RUN and beats game over.
  always_comb begin
    state_d = state_q;
    if (game_start_pulse)                         state_d = RUN;
    else if (state_q == RUN && game_over_pulse)   state_d = OVER;
  end

  // FSM outputs: the world only moves in RUN.
  always_comb begin
    run = (state_q == RUN);
  end

  assign scroll  = run && game_tick[0];
  assign gap_dec = (gap_q == 6'd0) ? 6'd0 : gap_q - 6'd1;
  assign spawn_en = scroll && (gap_dec == 6'd0) && lfsr_q[0];

  // Lowest free slot takes the spawn; a slot retiring this tick counts as free.
  always_comb begin
    logic taken;
    taken = 1'b0;
    load  = '0;
    for (int i = 0; i < NUM_OBS; i++) begin
      if (spawn_en && free[i] && !taken) begin
        load[i] = 1'b1;
        taken   = 1'b1;
      end
    end
  end

  // Gap, speed ramp and crash next state.
  always_comb begin
    gap_d   = gap_q;
    fcnt_d  = fcnt_q;
    speed_d = speed_q;
    crash_d = crash_q;
    if (game_start_pulse) begin
      gap_d   = MIN_GAP;
      fcnt_d  = 10'd0;
      speed_d = SPEED_INIT;
      crash_d = 1'b0;
    end else begin
      if (scroll) begin
        gap_d = (|load) ? (MIN_GAP + {1'b0, lfsr_q[7:3]}) : gap_dec;
        if (fcnt_q == SPEED_PERIOD - 10'd1) begin
          fcnt_d  = 10'd0;
          speed_d = (speed_q >= SPEED_MAX) ? SPEED_MAX : speed_q + 3'd1;
        end else begin
          fcnt_d = fcnt_q + 10'd1;
        end
      end
      if (run && game_tick[1]) crash_d = |hit;
    end
  end

  // Counter, LFSR and crash registers; the LFSR free-runs in every state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lfsr_q  <= LFSR_SEED;
      gap_q   <= MIN_GAP;
      fcnt_q  <= 10'd0;
      speed_q <= SPEED_INIT;
      crash_q <= 1'b0;
    end else begin
      lfsr_q  <= lfsr_next(lfsr_q);
      gap_q   <= gap_d;
      fcnt_q  <= fcnt_d;
      speed_q <= speed_d;
      crash_q <= crash_d;
    end
  end

  for (genvar g = 0; g < NUM_OBS; g++) begin : g_slot
    obstacle_slot #(
      .SCREEN_R (SCREEN_R),  .PLAYER_X (PLAYER_X),  .PLAYER_W (PLAYER_W),
      .PLAYER_H (PLAYER_H),  .PLAYER_DH(PLAYER_DH), .CACTUS_W (CACTUS_W),
      .CACTUS_H (CACTUS_H),  .BIRD_W   (BIRD_W),    .BIRD_Y   (BIRD_Y),
      .BIRD_H   (BIRD_H)
    ) u_slot (
      .clk         (clk),
      .rst_n       (rst_n),
      .clear_i     (game_start_pulse),
      .scroll_i    (scroll),
      .load_i      (load[g]),
      .load_type_i (lfsr_q[1] & lfsr_q[2]),
      .speed_i     (speed_q),
      .player_pos_i(player_position),
      .ducking_i   (ducking),
      .valid_o     (obs_valid[g]),
      .type_o      (obs_type[g]),
      .x_o         (obs_x[8*g +: 8]),
      .free_o      (free[g]),
      .hit_o       (hit[g])
    );
  end

  assign crash = crash_q;
  assign speed = speed_q;

endmodule

// File: tb/tb_obstacle_controller.sv
// tb/tb_obstacle_controller.sv - randomized self-checking bench for obstacle_controller
module tb_obstacle_controller;

  localparam int N = 2;

  logic           clk = 1'b0;
  logic           rst_n = 1'b1;
  logic [1:0]     game_tick = 2'b00;
  logic           game_start_pulse = 1'b0;
  logic           game_over_pulse = 1'b0;
  logic [7:0]     player_position = 8'd0;
  logic           ducking = 1'b0;
  logic           crash;
  logic [N-1:0]   obs_valid;
  logic [N-1:0]   obs_type;
  logic [8*N-1:0] obs_x;
  logic [2:0]     speed;

  int checks = 0;
  int errors = 0;

  // Reference world: mode 0 idle, 1 running, 2 frozen after game over.
  int m_mode, m_lfsr, m_gap, m_frames, m_speed, m_crash;
  int m_v[N], m_t[N], m_x[N];

  obstacle_controller dut (
    .clk(clk), .rst_n(rst_n), .game_tick(game_tick),
    .game_start_pulse(game_start_pulse), .game_over_pulse(game_over_pulse),
    .player_position(player_position), .ducking(ducking),
    .crash(crash), .obs_valid(obs_valid), .obs_type(obs_type),
    .obs_x(obs_x), .speed(speed)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < N; i++) begin m_v[i] = 0; m_t[i] = 0; m_x[i] = 0; end
    m_crash = 0; m_speed = 1; m_gap = 24; m_frames = 0;
  endtask

  task automatic model_reset();
    model_clear();
    m_mode = 0;
    m_lfsr = 'hACE1;
  endtask

  // One clock edge of the game world computed from the rules directly.
  task automatic model_step();
    int nl, w, ylo, yhi, ph, slot;
    bit fr[N];
    bit hit;
    if (!rst_n) begin model_reset(); return; end
    nl = (m_lfsr % 2 == 1) ? ((m_lfsr / 2) ^ 'hB400) : (m_lfsr / 2);
    if (game_start_pulse) begin
      model_clear();
      m_mode = 1;
    end else if (m_mode == 1) begin
      if (game_over_pulse) m_mode = 2;
      if (game_tick[0]) begin
        for (int i = 0; i < N; i++) begin
          fr[i] = (m_v[i] == 0);
          if (m_v[i] != 0) begin
            if (m_x[i] < m_speed) begin m_v[i] = 0; fr[i] = 1; end
            else m_x[i] = m_x[i] - m_speed;
          end
        end
        if (m_gap > 0) m_gap = m_gap - 1;
        if (m_gap == 0 && (m_lfsr % 2) == 1) begin
          slot = -1;
          for (int i = N - 1; i >= 0; i--) if (fr[i]) slot = i;
          if (slot >= 0) begin
            m_v[slot] = 1;
            m_x[slot] = 159;
            m_t[slot] = ((m_lfsr / 2) % 2) * ((m_lfsr / 4) % 2);
            m_gap = 24 + (m_lfsr / 8) % 32;
          end
        end
        m_frames++;
        if (m_frames == 600) begin
          m_frames = 0;
          if (m_speed < 6) m_speed++;
        end
      end
      if (game_tick[1]) begin
        hit = 0;
        ph = ducking ? 8 : 16;
        for (int i = 0; i < N; i++) begin
          w   = m_t[i] ? 10 : 6;
          ylo = m_t[i] ? 10 : 0;
          yhi = m_t[i] ? 16 : 12;
          if (m_v[i] != 0 && 16 < m_x[i] + w && m_x[i] < 24 &&
              player_position < yhi && ylo < player_position + ph) hit = 1;
        end
        m_crash = hit;
      end
    end
    m_lfsr = nl;
  endtask

  task automatic check_all();
    chk("crash", crash, m_crash);
    chk("speed", speed, m_speed);
    for (int i = 0; i < N; i++) begin
      chk($sformatf("valid%0d", i), obs_valid[i], m_v[i]);
      chk($sformatf("type%0d", i), obs_type[i], m_t[i]);
      chk($sformatf("x%0d", i), obs_x[8*i +: 8], m_x[i]);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    model_step();
    #1;
    check_all();
  endtask

  task automatic frame(input int idle);
    if ($urandom_range(0, 3) == 0) player_position = 8'($urandom_range(0, 24));
    ducking = 1'($urandom_range(0, 1));
    game_tick = 2'b01; cyc();
    game_tick = 2'b10; cyc();
    game_tick = 2'b00;
    repeat (idle) cyc();
  endtask

  task automatic run_frames(input int n);
    for (int f = 0; f < n; f++) frame($urandom_range(0, 2));
  endtask

  task automatic pulse_start();
    game_start_pulse = 1'b1; cyc();
    game_start_pulse = 1'b0; cyc();
  endtask

  task automatic pulse_over();
    game_over_pulse = 1'b1; cyc();
    game_over_pulse = 1'b0; cyc();
  endtask

  initial begin
    model_reset();
    #2 rst_n = 1'b0;
    repeat (3) cyc();
    chk("rst_crash", crash, 0);
    chk("rst_valid", obs_valid, 0);
    chk("rst_x", obs_x, 0);
    chk("rst_speed", speed, 1);
    rst_n = 1'b1;
    run_frames(5);
    chk("idle_valid", obs_valid, 0);

    pulse_start();
    chk("start_speed", speed, 1);
    run_frames(23);
    chk("gap_min_valid", obs_valid, 0);
    run_frames(3100);
    chk("speed_sat", speed, 6);

    pulse_over();
    run_frames(10);
    pulse_start();
    chk("restart_valid", obs_valid, 0);
    chk("restart_crash", crash, 0);
    chk("restart_speed", speed, 1);
    run_frames(200);

    rst_n = 1'b0;
    #1;
    chk("async_valid", obs_valid, 0);
    chk("async_speed", speed, 1);
    chk("async_crash", crash, 0);
    model_reset();
    cyc();
    rst_n = 1'b1;
    run_frames(3);

    for (int r = 0; r < 4; r++) begin
      pulse_start();
      run_frames($urandom_range(50, 400));
      if ($urandom_range(0, 1) == 1) begin
        pulse_over();
        run_frames(10);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
